// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS datapath and its controller:
// opcodes, ALU operation codes, mux select encodings and the FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] S_INIT      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_R_EXEC    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_I_EXEC    = 4'd9;
    localparam logic [3:0] S_I_WB      = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;

endpackage

// File: rtl/imm_aluop_decode.sv
// Maps an I-type opcode to the ALU operation used in the I_EXEC state.
module imm_aluop_decode
    import mips_pkg::*;
(
    input  logic [5:0] OP,
    output logic [2:0] ALUOp
);

    always_comb begin
        case (OP)
            OP_ANDI: ALUOp = ALU_AND;
            OP_ORI:  ALUOp = ALU_OR;
            OP_LUI:  ALUOp = ALU_LUI;
            default: ALUOp = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM: steps each instruction through fetch,
// decode, execute, memory and write-back, stalling on MemReady.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCondEQ,
    output logic       PCWriteCondNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       IllegalOp,
    output logic [3:0] State
);

    logic [3:0] r_state;
    logic       r_run;
    logic [3:0] w_next;
    logic [2:0] w_imm_aluop;
    logic       w_unused_zero;

    // Branch resolution lives in the datapath; the flag is accepted but not used here.
    assign w_unused_zero = Zero;
    assign State         = r_state;

    imm_aluop_decode u_imm_aluop_decode (
        .OP    (OP),
        .ALUOp (w_imm_aluop)
    );

    // r_run delays the INIT->FETCH step by one edge so INIT spans a full cycle after release.
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next        = r_state;
        PCWrite       = 1'b0;
        PCWriteCondEQ = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_B;
        PCSource      = PCSRC_ALU;
        ALUOp         = ALU_ADD;
        IllegalOp     = 1'b0;

        case (r_state)
            S_INIT: begin
                if (r_run) w_next = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SL2;
                case (OP)
                    OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
                    OP_R:                             w_next = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_I_EXEC;
                    OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
                    OP_J:                             w_next = S_JUMP;
                    default: begin
                        IllegalOp = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next  = (OP == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) w_next = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                w_next  = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = w_imm_aluop;
                w_next  = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_SUB;
                PCSource      = PCSRC_ALUOUT;
                PCWriteCondEQ = (OP == OP_BEQ);
                PCWriteCondNE = (OP == OP_BNE);
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                w_next   = S_FETCH;
            end
            default: w_next = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: builds the expected per-cycle trace of each instruction
// from the instruction-level behaviour and compares State and all strobes.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw, ceq, cne, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] op;
        outs_t      o;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OP = 6'h00;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;
    outs_t      got;

    int    n_cmp = 0;
    int    n_err = 0;
    step_t q[$];

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .OP            (OP),
        .Zero          (Zero),
        .MemReady      (MemReady),
        .PCWrite       (PCWrite),
        .PCWriteCondEQ (PCWriteCondEQ),
        .PCWriteCondNE (PCWriteCondNE),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .PCSource      (PCSource),
        .ALUOp         (ALUOp),
        .IllegalOp     (IllegalOp),
        .State         (State)
    );

    assign got = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op, input outs_t o);
        step_t s;
        s.st = st; s.mr = mr; s.op = op; s.o = o;
        q.push_back(s);
    endtask

    task automatic push_init();
        push(4'd0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), '0);
    endtask

    // Expected trace of one instruction: fs fetch stalls, ms data-memory stalls.
    task automatic gen(input logic [5:0] op, input int fs, input int ms);
        outs_t o;
        for (int i = 0; i < fs; i++) begin
            o = '0; o.mrd = 1; o.srcb = 2'b01;
            push(4'd1, 1'b0, op, o);
        end
        o = '0; o.mrd = 1; o.srcb = 2'b01; o.irw = 1; o.pcw = 1;
        push(4'd1, 1'b1, op, o);
        o = '0; o.srcb = 2'b11; o.ill = !is_legal(op);
        push(4'd2, 1'($urandom_range(0, 1)), op, o);
        if (!is_legal(op)) return;
        case (op)
            6'h23, 6'h2B: begin
                o = '0; o.srca = 1; o.srcb = 2'b10;
                push(4'd3, 1'($urandom_range(0, 1)), op, o);
                if (op == 6'h23) begin
                    o = '0; o.mrd = 1; o.iord = 1;
                    for (int i = 0; i < ms; i++) push(4'd4, 1'b0, op, o);
                    push(4'd4, 1'b1, op, o);
                    o = '0; o.rwr = 1; o.m2r = 1;
                    push(4'd5, 1'($urandom_range(0, 1)), op, o);
                end else begin
                    o = '0; o.mwr = 1; o.iord = 1;
                    for (int i = 0; i < ms; i++) push(4'd6, 1'b0, op, o);
                    push(4'd6, 1'b1, op, o);
                end
            end
            6'h00: begin
                o = '0; o.srca = 1; o.aluop = 3'b111;
                push(4'd7, 1'($urandom_range(0, 1)), op, o);
                o = '0; o.rwr = 1; o.rdst = 1;
                push(4'd8, 1'($urandom_range(0, 1)), op, o);
            end
            6'h04, 6'h05: begin
                o = '0; o.srca = 1; o.aluop = 3'b100; o.pcsrc = 2'b01;
                o.ceq = (op == 6'h04); o.cne = (op == 6'h05);
                push(4'd11, 1'($urandom_range(0, 1)), op, o);
            end
            6'h02: begin
                o = '0; o.pcw = 1; o.pcsrc = 2'b10;
                push(4'd12, 1'($urandom_range(0, 1)), op, o);
            end
            default: begin
                o = '0; o.srca = 1; o.srcb = 2'b10;
                o.aluop = (op == 6'h0C) ? 3'b011 : (op == 6'h0D) ? 3'b001 :
                          (op == 6'h0F) ? 3'b010 : 3'b000;
                push(4'd9, 1'($urandom_range(0, 1)), op, o);
                o = '0; o.rwr = 1;
                push(4'd10, 1'($urandom_range(0, 1)), op, o);
            end
        endcase
    endtask

    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            MemReady = s.mr;
            OP = s.op;
            #1;
            check("state", 32'(State), 32'(s.st));
            check("outs", 32'(got), 32'(s.o));
            check("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
            check("ill_rw_excl", 32'(IllegalOp & RegWrite), 32'd0);
        end
    endtask

    initial begin
        logic [5:0] legal_ops [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
                                       6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        logic [5:0] op;
        step_t      last;

        // Held in reset across several edges.
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(State), 32'd0);
        check("rst_outs", 32'(got), 32'd0);

        @(posedge clk);
        #2 reset = 1'b1;
        push_init();
        push_init();

        // Directed instructions from the test plan.
        gen(6'h00, 0, 0);
        gen(6'h23, 0, 2);
        gen(6'h2B, 3, 0);
        gen(6'h05, 0, 0);
        gen(6'h02, 0, 0);
        gen(6'h3F, 0, 0);
        gen(6'h04, 1, 0);
        run_q();

        // Reset asserted while a store waits in MEM_WRITE.
        gen(6'h2B, 0, 0);
        last = q.pop_back();
        last.mr = 1'b0;
        q.push_back(last);
        run_q();
        #1 reset = 1'b0;
        #1;
        check("midrst_state", 32'(State), 32'd0);
        check("midrst_memwrite", 32'(MemWrite), 32'd0);
        check("midrst_outs", 32'(got), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_hold", 32'(State), 32'd0);
        #1 reset = 1'b1;
        push_init();
        push_init();
        gen(6'h0D, 0, 0);
        run_q();

        // Randomized instruction stream with random stalls.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 9)];
            end
            gen(op, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
            run_q();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath. It replaces single-cycle opcode decoding with a Moore/Mealy state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives the shared memory port, IR, PC, ALU and register-file enables, and stalls on a memory-ready handshake. It sits beside the datapath top level, takes OP from the instruction register and returns every datapath strobe.

## Interface
- NONE: no parameters. Opcode and state constants come from the shared package.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; forces state INIT
- OP  in  6  opcode field of the instruction register
- Zero  in  1  ALU zero flag; informational only, branch resolution is done in the datapath via PCWriteCondEQ/NE
- MemReady  in  1  memory completes the access presented this cycle
- PCWrite, PCWriteCondEQ, PCWriteCondNE  out  1  unconditional and conditional PC enables
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead, MemWrite, IRWrite  out  1  memory port strobes and IR load
- MemtoReg, RegDst, RegWrite  out  1  write-back select, destination select, register-file write
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  out  3  000 add, 001 or, 010 lui, 011 and, 100 sub, 111 use funct
- IllegalOp  out  1  one-cycle pulse on an undecodable opcode
- State  out  4  current state, for debug

## Operation
- Opcodes: R = 0x00, J = 0x02, BEQ = 0x04, BNE = 0x05, ADDI = 0x08, ANDI = 0x0C, ORI = 0x0D, LUI = 0x0F, LW = 0x23, SW = 0x2B.
- Any output not listed for a state is 0 in that state.
- INIT: no outputs asserted. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000.
  - If MemReady=1: IRWrite=1, PCWrite=1, PCSource=00, and next state is DECODE.
  - If MemReady=0: no IRWrite or PCWrite, and the state holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (computes the branch target).
  - LW/SW go to MEM_ADDR.
  - R goes to R_EXEC.
  - ADDI/ANDI/ORI/LUI go to I_EXEC.
  - BEQ/BNE go to BRANCH.
  - J goes to JUMP.
  - Any other opcode: IllegalOp=1, next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. LW goes to MEM_READ; SW goes to MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state is FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until MemReady=1, then goes to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next state is R_WB.
- R_WB: RegWrite=1, RegDst=1. Next state is FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp is 000 for ADDI, 011 for ANDI, 001 for ORI, 010 for LUI. Next state is I_WB.
  - OP is sampled from the IR, which is stable between IRWrite pulses.
- I_WB: RegWrite=1, RegDst=0. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCSource=01. PCWriteCondEQ=1 for BEQ; PCWriteCondNE=1 for BNE. Next state is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state is FETCH.

## Timing
- Reset values: State = INIT and every output 0, held for the whole time reset=0.
- The first FETCH occurs in the second rising edge after reset is released (INIT lasts one cycle).
- Outputs are combinational from State, plus OP and MemReady where noted above. There are no output registers.
- Latency with MemReady tied high (cycles per instruction):
  - LW: 5
  - SW: 4
  - R and I-type: 4
  - BEQ/BNE: 3
  - J: 3
  - Illegal opcode: 2
- Every cycle spent with MemReady=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- MemRead and MemWrite are never asserted in the same cycle.
- MemWrite is never asserted outside MEM_WRITE.
- Reset asserted mid-instruction: INIT is entered immediately (asynchronously) and all strobes drop that cycle. A pending memory access is abandoned.
- IllegalOp and RegWrite are never high simultaneously.

## Structure
- Shared package mips_pkg holds:
  - opcode localparams
  - ALUOp codes
  - ALUSrcB and PCSource select encodings
  - the 4-bit state encoding (INIT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12)
- One sub-module, imm_aluop_decode, maps OP to the I-type ALUOp. It is combinational.
- The state register and next-state/output logic stay in multicycle_control.

## Test plan
- Reset release with MemReady=1, OP=0x00: State goes INIT → FETCH → DECODE → R_EXEC → R_WB → FETCH. ALUOp=111 in R_EXEC; RegWrite=1 and RegDst=1 only in R_WB.
- LW (OP=0x23) with MemReady low for 2 cycles in MEM_READ: instruction takes 7 cycles. MemRead=1 and IorD=1 are held throughout the wait. RegWrite=1 with MemtoReg=1 occurs exactly once.
- SW (OP=0x2B), FETCH with MemReady=0 for 3 cycles: IRWrite=0 and PCWrite=0 during the stall. A single IRWrite pulse occurs. MemWrite is high only in MEM_WRITE. RegWrite is never asserted.
- BNE (OP=0x05) then J (OP=0x02): BRANCH asserts PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=100. JUMP asserts PCWrite=1, PCSource=10. Each takes 3 cycles.
- OP=0x3F: IllegalOp pulses for one cycle in DECODE, the next state is FETCH, and no RegWrite or MemWrite is issued.
- reset dropped during MEM_WRITE: MemWrite falls the same cycle, State reads 0, and FETCH resumes two cycles after release.
